// File: rtl/vx_barrier_unit.sv
// Warp barrier unit: counts arrivals per barrier id, stalls arriving warps, releases them together.
// Optional VX_BARRIER_PERF_EN adds a 44-bit stalled-warp-cycle counter output.
module vx_barrier_unit #(
    parameter int unsigned NUM_WARPS    = 4,
    parameter int unsigned NUM_BARRIERS = 4,
    parameter int unsigned NW_BITS      = $clog2(NUM_WARPS),
    parameter int unsigned NB_BITS      = $clog2(NUM_BARRIERS),
    localparam int unsigned NW_W        = (NW_BITS > 0) ? NW_BITS : 1,
    localparam int unsigned NB_W        = (NB_BITS > 0) ? NB_BITS : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 bar_valid,
    output logic                 bar_ready,
    input  logic [NW_W-1:0]      bar_wid,
    input  logic [NB_W-1:0]      bar_id,
    input  logic [NW_W-1:0]      bar_size_m1,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_mask,
`ifdef VX_BARRIER_PERF_EN
    output logic [43:0]          perf_stall_cycles,
`endif
    output logic                 busy
);

    logic                 r_ready;
    logic [NW_W-1:0]      r_cnt   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] r_wmask [NUM_BARRIERS];
    logic                 r_rel_valid;
    logic [NUM_WARPS-1:0] r_rel_mask;

    logic                 w_accept;
    logic                 w_last;
    logic [NUM_WARPS-1:0] w_wid_oh;
    logic [NUM_WARPS-1:0] w_stall;

    assign w_accept = bar_valid && r_ready;
    assign w_last   = (r_cnt[bar_id] == bar_size_m1);
    assign w_wid_oh = NUM_WARPS'(1) << bar_wid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready     <= 1'b0;
            r_rel_valid <= 1'b0;
            r_rel_mask  <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_cnt[b]   <= '0;
                r_wmask[b] <= '0;
            end
        end else begin
            // Backpressure is never applied; ready only marks the first cycle out of reset.
            r_ready     <= 1'b1;
            r_rel_valid <= w_accept && w_last;
            r_rel_mask  <= (w_accept && w_last) ? (r_wmask[bar_id] | w_wid_oh) : '0;
            if (w_accept) begin
                if (w_last) begin
                    r_cnt[bar_id]   <= '0;
                    r_wmask[bar_id] <= '0;
                end else begin
                    r_cnt[bar_id]   <= r_cnt[bar_id] + 1'b1;
                    r_wmask[bar_id] <= r_wmask[bar_id] | w_wid_oh;
                end
            end
        end
    end

    always_comb begin
        w_stall = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_stall = w_stall | r_wmask[b];
        end
    end

    assign bar_ready     = r_ready;
    assign stall_mask    = w_stall;
    assign busy          = |w_stall;
    assign release_valid = r_rel_valid;
    assign release_mask  = r_rel_mask;

`ifdef VX_BARRIER_PERF_EN
    logic [43:0] r_perf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf <= '0;
        end else begin
            r_perf <= r_perf + 44'($countones(w_stall));
        end
    end

    assign perf_stall_cycles = r_perf;
`endif

`ifndef SYNTHESIS
    // Size of the first arrival per barrier, kept only to flag inconsistent later arrivals.
    logic [NW_W-1:0] r_sz [NUM_BARRIERS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                r_sz[b] <= '0;
            end
        end else if (w_accept && (r_cnt[bar_id] == '0)) begin
            r_sz[bar_id] <= bar_size_m1;
        end
    end

    always @(posedge clk) begin
        if (reset_n && w_accept) begin
            assert (int'(bar_wid) < NUM_WARPS)
                else $error("barrier: warp id %0d out of range", bar_wid);
            assert (!w_stall[bar_wid])
                else $error("barrier: warp %0d arrived while already stalled", bar_wid);
            assert ((r_cnt[bar_id] == '0) || (r_sz[bar_id] == bar_size_m1))
                else $error("barrier: size mismatch on barrier %0d", bar_id);
        end
    end
`endif

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Bench for vx_barrier_unit: directed scenarios plus legal random traffic checked against a
// per-warp "waiting at barrier" model.
module tb_vx_barrier_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       bar_valid = 1'b0;
    logic       bar_ready;
    logic [1:0] bar_wid = '0;
    logic [1:0] bar_id = '0;
    logic [1:0] bar_size_m1 = '0;
    logic [3:0] stall_mask;
    logic       release_valid;
    logic [3:0] release_mask;
    logic       busy;
`ifdef VX_BARRIER_PERF_EN
    logic [43:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    vx_barrier_unit #(
        .NUM_WARPS    (4),
        .NUM_BARRIERS (4)
    ) dut (
`ifdef VX_BARRIER_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .clk           (clk),
        .reset_n       (reset_n),
        .bar_valid     (bar_valid),
        .bar_ready     (bar_ready),
        .bar_wid       (bar_wid),
        .bar_id        (bar_id),
        .bar_size_m1   (bar_size_m1),
        .stall_mask    (stall_mask),
        .release_valid (release_valid),
        .release_mask  (release_mask),
        .busy          (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: which barrier each warp waits at (-1 = running), and size of each open barrier.
    int          wait_at [4];
    int          bsize   [4];
    bit          exp_ready;
    bit          exp_rel_v;
    logic [3:0]  exp_rel_m;
    logic [43:0] exp_perf;

    function automatic logic [3:0] waiting_on(int b);
        logic [3:0] m = '0;
        for (int w = 0; w < 4; w++) if (wait_at[w] == b) m[w] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] exp_stall();
        logic [3:0] m = '0;
        for (int w = 0; w < 4; w++) if (wait_at[w] >= 0) m[w] = 1'b1;
        return m;
    endfunction

    function automatic int arrived(int b);
        return $countones(waiting_on(b));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            wait_at[i] = -1;
            bsize[i]   = 0;
        end
        exp_ready = 1'b0;
        exp_rel_v = 1'b0;
        exp_rel_m = '0;
        exp_perf  = '0;
    endtask

    task automatic model_edge(bit v, int w, int b, int sz);
        exp_perf  = exp_perf + 44'($countones(exp_stall()));
        exp_rel_v = 1'b0;
        exp_rel_m = '0;
        if (v && exp_ready) begin
            if (arrived(b) == sz) begin
                exp_rel_v = 1'b1;
                exp_rel_m = waiting_on(b) | (4'b0001 << w);
                for (int i = 0; i < 4; i++) if (wait_at[i] == b) wait_at[i] = -1;
            end else begin
                wait_at[w] = b;
                bsize[b]   = sz;
            end
        end
        exp_ready = 1'b1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("bar_ready", 64'(bar_ready), 64'(exp_ready));
        chk("stall_mask", 64'(stall_mask), 64'(exp_stall()));
        chk("busy", 64'(busy), 64'(exp_stall() != 4'b0));
        chk("release_valid", 64'(release_valid), 64'(exp_rel_v));
        chk("release_mask", 64'(release_mask), 64'(exp_rel_m));
`ifdef VX_BARRIER_PERF_EN
        chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(exp_perf));
`endif
    endtask

    // Drive one request (or idle cycle) just after a falling edge, check at the next falling edge.
    task automatic cycle(bit v, int w, int b, int sz);
        bar_valid   = v;
        bar_wid     = w[1:0];
        bar_id      = b[1:0];
        bar_size_m1 = sz[1:0];
        @(posedge clk);
        model_edge(v, w, b, sz);
        @(negedge clk);
        check_outputs();
    endtask

    // Legal random request: new barrier sizes never exceed the warps not already promised elsewhere.
    task automatic random_step();
        int free = 0;
        int needs = 0;
        int avail;
        int cand [$];
        int b;
        int sz;
        int w;
        int freew [$];
        for (int i = 0; i < 4; i++) if (wait_at[i] < 0) freew.push_back(i);
        free = freew.size();
        for (int i = 0; i < 4; i++) if (arrived(i) > 0) needs += bsize[i] + 1 - arrived(i);
        avail = free - needs;
        if ($urandom_range(0, 3) == 0 || free == 0) begin
            cycle(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (arrived(i) > 0 || avail >= 1) cand.push_back(i);
        end
        b  = cand[$urandom_range(0, cand.size() - 1)];
        sz = (arrived(b) > 0) ? bsize[b] : int'($urandom_range(0, avail - 1));
        w  = freew[$urandom_range(0, free - 1)];
        cycle(1'b1, w, b, sz);
    endtask

    initial begin
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        reset_n = 1'b1;
        #1 check_outputs();
        cycle(1'b0, 0, 0, 0);

        // Single-warp barrier releases immediately.
        cycle(1'b1, 2, 0, 0);
        cycle(1'b0, 0, 0, 0);

        // Four-warp barrier, then confirm its count returned to zero.
        cycle(1'b1, 0, 1, 3);
        cycle(1'b1, 1, 1, 3);
        cycle(1'b1, 2, 1, 3);
        cycle(1'b1, 3, 1, 3);
        cycle(1'b1, 0, 1, 0);
        cycle(1'b0, 0, 0, 0);

        // Interleaved independent barriers with back-to-back releases.
        cycle(1'b1, 0, 0, 1);
        cycle(1'b1, 2, 2, 1);
        cycle(1'b1, 1, 0, 1);
        cycle(1'b1, 3, 2, 1);
        cycle(1'b0, 0, 0, 0);

        // Mid-cycle asynchronous reset drops suspended warps without a pulse.
        cycle(1'b1, 0, 3, 2);
        cycle(1'b1, 1, 3, 2);
        bar_valid = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_outputs();
        #1 reset_n = 1'b1;
        cycle(1'b0, 0, 0, 0);
        cycle(1'b1, 0, 3, 2);
        cycle(1'b1, 1, 3, 2);
        cycle(1'b1, 2, 3, 2);

        // Two warps held for ten cycles (stall-cycle counter when enabled).
        cycle(1'b1, 0, 1, 3);
        cycle(1'b1, 1, 1, 3);
        repeat (10) cycle(1'b0, 0, 0, 0);
        cycle(1'b1, 2, 1, 3);
        cycle(1'b1, 3, 1, 3);

        repeat (400) random_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vx_barrier_unit.md
Name: vx_barrier_unit

Overview:
- Responder side of the warp-barrier request (valid, id, size_m1) issued by the GPU unit on a BAR instruction.
- Tracks arrivals per barrier ID, suspends arriving warps, and releases all participants once the last one arrives.
- Sits between the GPU execute unit and the warp scheduler; the scheduler masks issue with stall_mask and re-activates warps on release.

Parameters:
- NUM_WARPS, 4, warps per core (>=1)
- NUM_BARRIERS, 4, barrier IDs per core (>=1)
- NW_BITS, clog2(NUM_WARPS), warp-id width; ports use UP(NW_BITS), i.e. minimum 1
- NB_BITS, clog2(NUM_BARRIERS), barrier-id width; ports use UP(NB_BITS), i.e. minimum 1

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- bar_valid  in  1  barrier request valid
- bar_ready  out  1  unit can accept a request
- bar_wid  in  UP(NW_BITS)  arriving warp id
- bar_id  in  UP(NB_BITS)  barrier id
- bar_size_m1  in  UP(NW_BITS)  participating warps minus 1
- stall_mask  out  NUM_WARPS  warps suspended at any barrier
- release_valid  out  1  single-cycle release pulse
- release_mask  out  NUM_WARPS  warps released this cycle
- busy  out  1  at least one barrier holds arrivals

Behaviour:
- Reset:
  - All outputs are 0 while reset_n is low: bar_ready, stall_mask, release_valid, release_mask, busy.
  - All barrier counts and masks clear to 0.
  - bar_ready rises on the first clk edge after reset_n deasserts. It then stays 1 permanently; backpressure is reserved and never asserted.
- State per barrier b:
  - cnt[b], UP(NW_BITS) bits
  - wmask[b], NUM_WARPS bits
- Accept: on bar_valid && bar_ready at a rising edge. Let b = bar_id, w = bar_wid.
  - Release case, when cnt[b] == bar_size_m1 (last arrival):
    - Next cycle: release_valid = 1 and release_mask = wmask[b] | (1<<w).
    - cnt[b] <= 0, wmask[b] <= 0.
    - The released bits clear in stall_mask in the same cycle release_valid is high.
    - Warp w never appears in stall_mask.
  - Arrival case, otherwise:
    - cnt[b] <= cnt[b]+1, wmask[b][w] <= 1.
    - stall_mask[w] is 1 from the next cycle.
    - release_valid stays 0.
- Special cases:
  - bar_size_m1 == 0: immediate single-warp release; release_mask = 1<<w one cycle later.
  - The comparison uses the current request's size_m1. Mismatched sizes across arrivals are a protocol error (simulation assertion); hardware behaviour follows the rule above.
- Derived outputs:
  - stall_mask = OR of all wmask[b], registered view.
  - busy = stall_mask != 0.
- Pulse timing:
  - release_valid is high for exactly one cycle per completing request.
  - Back-to-back completions on different barriers produce back-to-back pulses, with each mask in its own cycle.
- Latency: request to release pulse, or to stall bit set, is 1 cycle.
- Throughput: one request per cycle.
- Protocol errors:
  - Arrival from a warp already set in stall_mask, or bar_wid >= NUM_WARPS: assertion fires. Hardware ORs the bit and counts it.
  - Count wrap is impossible under legal use, since size_m1 <= NUM_WARPS-1.
- Different barrier IDs are fully independent; distinct barriers may hold disjoint warps simultaneously.
- Reset mid-operation: asynchronous clear of all state.
  - Suspended warps are dropped without a release pulse.
  - The scheduler is reset in the same domain.

Optional Feature:
- Macro: VX_BARRIER_PERF_EN
- Enabled:
  - Adds output perf_stall_cycles, 44 bits.
  - Increments by popcount(stall_mask) every cycle; wraps on overflow.
  - Reset value 0.
- Disabled: the port and counter are absent; no other behaviour change.

Test Plan:
- Default params; reset_n low 3 cycles, then high → all outputs 0 during reset; bar_ready = 1 one edge after deassert.
- Request wid=2, id=0, size_m1=0 → release_valid = 1 next cycle with release_mask = 4'b0100; stall_mask stays 0.
- id=1, size_m1=3; wids 0, 1, 2 on consecutive cycles:
  - stall_mask goes 0001 → 0011 → 0111.
  - wid 3 arrives → release_mask = 1111 with stall_mask = 0000 in that cycle, and cnt[1] returns to 0.
- Interleaved barriers:
  - id=0 size_m1=1 with wid 0 then wid 1, interleaved with id=2 size_m1=1 with wid 2 then wid 3 on alternate cycles.
  - Two pulses result: 0011 then 1100, and barriers do not interfere.
- id=3, size_m1=2; wids 0 and 1 arrive, then reset_n is pulsed low mid-cycle → stall_mask clears asynchronously, no release pulse; next request from wid 0 gives cnt = 1.
- VX_BARRIER_PERF_EN: two warps stalled for 10 cycles → perf_stall_cycles = 20.
